write_ctrl: RTL and testbench

- Sequences one WRITE datapath instance per job.
- Accepts a job descriptor (iterations, reads per iteration, base address, clip bounds) through a valid/ready handshake, then issues the one-cycle configure pulse with the registered job fields.
- Counts WRITE output writes (valid_out beats) until the expected total is reached, then pulses done.
- Sits between the layer scheduler and the WRITE block; also provides abort and busy status.

---
 rtl/write_ctrl_pkg.sv | 23 ++
 rtl/write_ctrl_counter.sv | 53 +++++
 rtl/write_ctrl.sv | 166 ++++++++++++++++
 tb/tb_write_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/write_ctrl_pkg.sv
// write_ctrl_pkg: shared types and constants for the WRITE sequencing controller.
//   state_e  : controller state encoding (IDLE/CONFIG/RUN/DONE)
//   default widths for the job descriptor fields and the write total
package write_ctrl_pkg;

    localparam int LOG_MAX_ITERS_DEF          = 16;
    localparam int LOG_MAX_READS_PER_ITER_DEF = 16;
    localparam int LOG_MAX_ADDRESS_DEF        = 16;
    localparam int OUTPUT_DATA_WIDTH_DEF      = 8;

    // iters*reads fits without overflow in the sum of the operand widths
    localparam int TOTAL_W = LOG_MAX_ITERS_DEF + LOG_MAX_READS_PER_ITER_DEF;

    localparam int PERF_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CONFIG = 2'd1,
        RUN    = 2'd2,
        DONE   = 2'd3
    } state_e;

endpackage

// File: rtl/write_ctrl_counter.sv
// write_ctrl_counter: up-counter with synchronous clear, increment, loadable
// terminal value and terminal-hit flag.
//   clk, rst     : clock, synchronous active-high reset
//   clr_i        : force count to 0 (wins over inc_i)
//   load_i       : capture load_val_i as the terminal value
//   inc_i        : advance count by one
//   cnt_o        : current count
//   tc_hit_o     : the next increment reaches the terminal value
// Parameter SAT holds the count at all-ones instead of wrapping.
module write_ctrl_counter #(
    parameter int W   = 32,
    parameter bit SAT = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o,
    output logic         tc_hit_o
);

    logic [W-1:0] cnt_q, cnt_d;
    logic [W-1:0] term_q, term_d;

    always_comb begin
        cnt_d  = cnt_q;
        term_d = term_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && !(SAT && (&cnt_q))) begin
            cnt_d = cnt_q + W'(1);
        end
        if (load_i) begin
            term_d = load_val_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            term_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            term_q <= term_d;
        end
    end

    assign cnt_o    = cnt_q;
    assign tc_hit_o = ((cnt_q + W'(1)) == term_q);

endmodule

// File: rtl/write_ctrl.sv
// write_ctrl: accepts a job descriptor, issues one configure pulse to the WRITE
// block with the registered job fields, counts WRITE output beats until
// iters*reads is reached, then pulses done. abort cancels a running job.
//   clk, rst            : clock, synchronous active-high reset
//   job_valid/job_ready : job descriptor handshake
//   job_*               : descriptor fields
//   abort               : cancel the job in CONFIG or RUN
//   configure           : one-cycle pulse to WRITE
//   num_iters .. max_clip : registered job fields, held until the next accept
//   wr_valid            : WRITE valid_out, counted only in RUN
//   busy, done, aborted : status; done/aborted are one-cycle pulses
//   perf_cycles         : CONFIG+RUN cycle count of the last job
//                         (only when WRITE_CTRL_PERF_EN is defined)
//
// state  | meaning
// IDLE   | job_ready high, waiting for a descriptor
// CONFIG | configure pulse, write count being cleared
// RUN    | counting wr_valid beats toward the total
// DONE   | done pulse, back to IDLE next cycle
module write_ctrl
    import write_ctrl_pkg::*;
#(
    parameter int LOG_MAX_ITERS          = LOG_MAX_ITERS_DEF,
    parameter int LOG_MAX_READS_PER_ITER = LOG_MAX_READS_PER_ITER_DEF,
    parameter int LOG_MAX_ADDRESS        = LOG_MAX_ADDRESS_DEF,
    parameter int OUTPUT_DATA_WIDTH      = OUTPUT_DATA_WIDTH_DEF
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              job_valid,
    output logic                              job_ready,
    input  logic [LOG_MAX_ITERS-1:0]          job_iters,
    input  logic [LOG_MAX_READS_PER_ITER-1:0] job_reads,
    input  logic [LOG_MAX_ADDRESS-1:0]        job_addr,
    input  logic [OUTPUT_DATA_WIDTH-1:0]      job_min_clip,
    input  logic [OUTPUT_DATA_WIDTH-1:0]      job_max_clip,
    input  logic                              abort,
    output logic                              configure,
    output logic [LOG_MAX_ITERS-1:0]          num_iters,
    output logic [LOG_MAX_READS_PER_ITER-1:0] num_reads_per_iter,
    output logic [LOG_MAX_ADDRESS-1:0]        base_address,
    output logic [OUTPUT_DATA_WIDTH-1:0]      min_clip,
    output logic [OUTPUT_DATA_WIDTH-1:0]      max_clip,
    input  logic                              wr_valid,
    output logic                              busy,
    output logic                              done,
    output logic                              aborted
`ifdef WRITE_CTRL_PERF_EN
    ,
    output logic [PERF_W-1:0]                 perf_cycles
`endif
);

    localparam int TW = LOG_MAX_ITERS + LOG_MAX_READS_PER_ITER;

    state_e          state_q;
    logic            accept;
    logic [TW-1:0]   job_total;
    logic [TW-1:0]   wr_cnt_unused;
    logic            wr_tc_hit;

    assign accept    = (state_q == IDLE) && job_valid;
    assign job_total = TW'(job_iters) * TW'(job_reads);

    // Terminal value is loaded on accept; the count is cleared during CONFIG
    // so beats from an earlier aborted job never leak into the new one.
    write_ctrl_counter #(.W(TW), .SAT(1'b0)) u_wr_cnt (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (state_q == CONFIG),
        .load_i     (accept),
        .load_val_i (job_total),
        .inc_i      ((state_q == RUN) && wr_valid),
        .cnt_o      (wr_cnt_unused),
        .tc_hit_o   (wr_tc_hit)
    );

`ifdef WRITE_CTRL_PERF_EN
    logic perf_tc_unused;

    write_ctrl_counter #(.W(PERF_W), .SAT(1'b1)) u_perf_cnt (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (accept),
        .load_i     (1'b0),
        .load_val_i ('0),
        .inc_i      ((state_q == CONFIG) || (state_q == RUN)),
        .cnt_o      (perf_cycles),
        .tc_hit_o   (perf_tc_unused)
    );
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q            <= IDLE;
            job_ready          <= 1'b1;
            configure          <= 1'b0;
            busy               <= 1'b0;
            done               <= 1'b0;
            aborted            <= 1'b0;
            num_iters          <= '0;
            num_reads_per_iter <= '0;
            base_address       <= '0;
            min_clip           <= '0;
            max_clip           <= '0;
        end else begin
            configure <= 1'b0;
            done      <= 1'b0;
            aborted   <= 1'b0;
            case (state_q)
                IDLE: begin
                    // abort is meaningless here; an accept proceeds regardless
                    if (job_valid) begin
                        num_iters          <= job_iters;
                        num_reads_per_iter <= job_reads;
                        base_address       <= job_addr;
                        min_clip           <= job_min_clip;
                        max_clip           <= job_max_clip;
                        job_ready          <= 1'b0;
                        busy               <= 1'b1;
                        if (job_total == '0) begin
                            state_q <= DONE;
                            done    <= 1'b1;
                        end else begin
                            state_q   <= CONFIG;
                            configure <= 1'b1;
                        end
                    end
                end
                CONFIG: begin
                    if (abort) begin
                        state_q   <= IDLE;
                        aborted   <= 1'b1;
                        busy      <= 1'b0;
                        job_ready <= 1'b1;
                    end else begin
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    // abort outranks a final beat arriving in the same cycle
                    if (abort) begin
                        state_q   <= IDLE;
                        aborted   <= 1'b1;
                        busy      <= 1'b0;
                        job_ready <= 1'b1;
                    end else if (wr_valid && wr_tc_hit) begin
                        state_q <= DONE;
                        done    <= 1'b1;
                    end
                end
                DONE: begin
                    state_q   <= IDLE;
                    busy      <= 1'b0;
                    job_ready <= 1'b1;
                end
                default: begin
                    state_q   <= IDLE;
                    busy      <= 1'b0;
                    job_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_write_ctrl.sv
module tb_write_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        job_valid;
    logic        job_ready;
    logic [15:0] job_iters;
    logic [15:0] job_reads;
    logic [15:0] job_addr;
    logic [7:0]  job_min_clip;
    logic [7:0]  job_max_clip;
    logic        abort;
    logic        configure;
    logic [15:0] num_iters;
    logic [15:0] num_reads_per_iter;
    logic [15:0] base_address;
    logic [7:0]  min_clip;
    logic [7:0]  max_clip;
    logic        wr_valid;
    logic        busy;
    logic        done;
    logic        aborted;
`ifdef WRITE_CTRL_PERF_EN
    logic [31:0] perf_cycles;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int perf_exp = 0;

    always #5 clk = ~clk;

    write_ctrl dut (
        .clk                (clk),
        .rst                (rst),
        .job_valid          (job_valid),
        .job_ready          (job_ready),
        .job_iters          (job_iters),
        .job_reads          (job_reads),
        .job_addr           (job_addr),
        .job_min_clip       (job_min_clip),
        .job_max_clip       (job_max_clip),
        .abort              (abort),
        .configure          (configure),
        .num_iters          (num_iters),
        .num_reads_per_iter (num_reads_per_iter),
        .base_address       (base_address),
        .min_clip           (min_clip),
        .max_clip           (max_clip),
        .wr_valid           (wr_valid),
        .busy               (busy),
        .done               (done),
        .aborted            (aborted)
`ifdef WRITE_CTRL_PERF_EN
        ,
        .perf_cycles        (perf_cycles)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_perf(input string tag);
`ifdef WRITE_CTRL_PERF_EN
        chk(tag, 64'(perf_cycles), 64'(perf_exp));
`endif
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs();
        chk("rst_ready", job_ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_cfg", configure, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_abort", aborted, 1'b0);
        chk("rst_iters", num_iters, 16'h0);
        chk("rst_reads", num_reads_per_iter, 16'h0);
        chk("rst_addr", base_address, 16'h0);
        chk("rst_min", min_clip, 8'h0);
        chk("rst_max", max_clip, 8'h0);
    endtask

    // Present a job while IDLE; afterwards sits in the cycle following accept.
    task automatic accept_job(input logic [15:0] it, input logic [15:0] rd, input logic [15:0] ad,
                              input logic [7:0] mn, input logic [7:0] mx, output longint total);
        total        = longint'(it) * longint'(rd);
        job_valid    = 1'b1;
        job_iters    = it;
        job_reads    = rd;
        job_addr     = ad;
        job_min_clip = mn;
        job_max_clip = mx;
        wr_valid     = 1'($urandom_range(0, 1));
        abort        = 1'($urandom_range(0, 1));
        chk("ready_idle", job_ready, 1'b1);
        step();
        job_valid    = 1'b0;
        abort        = 1'b0;
        wr_valid     = 1'b0;
        job_iters    = 16'($urandom);
        job_reads    = 16'($urandom);
        job_addr     = 16'($urandom);
        job_min_clip = 8'($urandom);
        job_max_clip = 8'($urandom);
        perf_exp     = 0;
        chk("acc_busy", busy, 1'b1);
        chk("acc_ready", job_ready, 1'b0);
        chk("acc_cfg", configure, total != 0);
        chk("acc_done", done, total == 0);
        chk("acc_iters", num_iters, it);
        chk("acc_reads", num_reads_per_iter, rd);
        chk("acc_addr", base_address, ad);
        chk("acc_min", min_clip, mn);
        chk("acc_max", max_clip, mx);
    endtask

    task automatic finish_zero();
        step();
        chk("zero_done_gone", done, 1'b0);
        chk("zero_busy", busy, 1'b0);
        chk("zero_ready", job_ready, 1'b1);
        chk("zero_cfg", configure, 1'b0);
    endtask

    // abort_at: -1 none, -2 abort during CONFIG, k>=0 abort instead of write k.
    task automatic drive_writes(input longint total, input int abort_at, input bit tail, input int maxgap);
        wr_valid = 1'($urandom_range(0, 1));
        if (abort_at == -2) begin
            abort = 1'b1;
            step();
            abort = 1'b0;
            wr_valid = 1'b0;
            perf_exp = 1;
            chk("cabort_pulse", aborted, 1'b1);
            chk("cabort_done", done, 1'b0);
            chk("cabort_busy", busy, 1'b0);
            chk("cabort_ready", job_ready, 1'b1);
            chk_perf("cabort_perf");
            return;
        end
        step();
        wr_valid = 1'b0;
        perf_exp = 1;
        chk("cfg_once", configure, 1'b0);
        chk("run_busy", busy, 1'b1);
        for (longint w = 0; w < total; w++) begin
            int gaps;
            gaps = int'($urandom_range(0, maxgap));
            for (int g = 0; g < gaps; g++) begin
                step();
                perf_exp++;
                chk("gap_done", done, 1'b0);
                chk("gap_busy", busy, 1'b1);
            end
            if (w == longint'(abort_at)) begin
                abort    = 1'b1;
                wr_valid = 1'($urandom_range(0, 1));
                step();
                abort    = 1'b0;
                wr_valid = 1'b0;
                perf_exp++;
                chk("abort_pulse", aborted, 1'b1);
                chk("abort_done", done, 1'b0);
                chk("abort_busy", busy, 1'b0);
                chk("abort_ready", job_ready, 1'b1);
                chk_perf("abort_perf");
                step();
                chk("abort_once", aborted, 1'b0);
                chk("abort_nodone", done, 1'b0);
                return;
            end
            wr_valid = 1'b1;
            step();
            wr_valid = 1'b0;
            perf_exp++;
            if (w == total - 1) begin
                chk("done_pulse", done, 1'b1);
                chk("done_noabort", aborted, 1'b0);
                chk("done_busy", busy, 1'b1);
                chk("done_ready", job_ready, 1'b0);
                chk_perf("done_perf");
            end else begin
                chk("early_done", done, 1'b0);
            end
        end
        if (tail) begin
            abort = 1'($urandom_range(0, 1));
            step();
            abort = 1'b0;
            chk("post_done", done, 1'b0);
            chk("post_abort", aborted, 1'b0);
            chk("post_busy", busy, 1'b0);
            chk("post_ready", job_ready, 1'b1);
            chk_perf("post_perf");
        end
    endtask

    initial begin
        longint tot;
        longint tot2;
        rst = 1'b1;
        job_valid = 1'b0;
        job_iters = '0;
        job_reads = '0;
        job_addr = '0;
        job_min_clip = '0;
        job_max_clip = '0;
        abort = 1'b0;
        wr_valid = 1'b0;
        repeat (3) step();
        chk_reset_outputs();
        rst = 1'b0;
        step();

        // basic job
        accept_job(16'd2, 16'd3, 16'h0040, 8'd0, 8'd127, tot);
        drive_writes(tot, -1, 1'b1, 2);

        // zero-length job
        accept_job(16'd0, 16'd5, 16'h0011, 8'd3, 8'd9, tot);
        finish_zero();

        // abort mid-RUN, then a normal job
        accept_job(16'd1, 16'd8, 16'h0100, 8'd1, 8'd200, tot);
        drive_writes(tot, 3, 1'b0, 1);
        accept_job(16'd1, 16'd2, 16'h0200, 8'd4, 8'd5, tot);
        drive_writes(tot, -1, 1'b1, 1);

        // abort during CONFIG
        accept_job(16'd3, 16'd1, 16'h0300, 8'd0, 8'd1, tot);
        drive_writes(tot, -2, 1'b0, 0);
        chk("cabort_hold_addr", base_address, 16'h0300);
        step();

        // back-to-back with job_valid held through DONE
        accept_job(16'd1, 16'd1, 16'h0A00, 8'd2, 8'd3, tot);
        drive_writes(tot, -1, 1'b0, 0);
        job_valid = 1'b1;
        job_iters = 16'd1;
        job_reads = 16'd2;
        job_addr = 16'h0B00;
        job_min_clip = 8'd7;
        job_max_clip = 8'd8;
        step();
        chk("b2b_ready", job_ready, 1'b1);
        chk("b2b_nocfg", configure, 1'b0);
        chk("b2b_not_sampled", base_address, 16'h0A00);
        step();
        job_valid = 1'b0;
        chk("b2b_cfg", configure, 1'b1);
        chk("b2b_addr", base_address, 16'h0B00);
        drive_writes(64'd2, -1, 1'b1, 1);

        // stray writes in IDLE are not counted
        wr_valid = 1'b1;
        repeat (3) step();
        wr_valid = 1'b0;
        chk("stray_busy", busy, 1'b0);
        accept_job(16'd1, 16'd3, 16'h0033, 8'd0, 8'd255, tot);
        drive_writes(tot, -1, 1'b1, 1);

        // reset mid-RUN after 2 of 4 writes
        accept_job(16'd2, 16'd2, 16'h0044, 8'd5, 8'd6, tot);
        step();
        wr_valid = 1'b1;
        repeat (2) step();
        wr_valid = 1'b0;
        rst = 1'b1;
        step();
        chk_reset_outputs();
        rst = 1'b0;
        wr_valid = 1'b1;
        step();
        wr_valid = 1'b0;
        chk("rst_nodone", done, 1'b0);
        chk("rst_idle_busy", busy, 1'b0);

        // perf job: 1 CONFIG + 4 RUN cycles
        accept_job(16'd1, 16'd4, 16'h0055, 8'd0, 8'd10, tot);
        drive_writes(tot, -1, 1'b1, 0);
`ifdef WRITE_CTRL_PERF_EN
        chk("perf_five", 64'(perf_cycles), 64'd5);
`endif

        // randomized jobs
        for (int j = 0; j < 40; j++) begin
            int r;
            int ab;
            accept_job(16'($urandom_range(0, 3)), 16'($urandom_range(0, 3)), 16'($urandom),
                       8'($urandom), 8'($urandom), tot2);
            if (tot2 == 0) begin
                finish_zero();
            end else begin
                r = int'($urandom_range(0, 9));
                ab = -1;
                if (r == 0) ab = -2;
                else if (r == 1) ab = int'($urandom_range(0, 32'(tot2 - 1)));
                drive_writes(tot2, ab, 1'b1, 2);
                if (ab == -2) step();
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
